execute_branch_resolver: RTL and testbench

- Sits at the end of the execute stage; it is the producer side of the fetch predictor's jump/update channel.
- Compares each resolved branch outcome against the prediction carried down the pipe.
- Emits one registered update strobe per resolved branch to the fetch predictor.
- On a mispredict, sequences a pipeline flush and a fetch redirect handshake; exposes saturating hit/miss statistics.

---
 rtl/execute_branch_resolver_if.sv | 43 ++++
 rtl/execute_branch_resolver.sv | 130 +++++++++++++
 tb/tb_execute_branch_resolver.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/execute_branch_resolver_if.sv
// Branch-resolve / predictor-update / redirect channel between execute and fetch.
// The resolver takes the master view; the pipeline environment takes the slave view.
interface execute_branch_resolver_if #(
    parameter int CNT_W = 16
);
    logic             iFLUSH;
    logic             iBR_VALID;
    logic [31:0]      iBR_INST_ADDR;
    logic             iBR_PREDICT;
    logic             iBR_HIT;
    logic [31:0]      iBR_PREDICT_ADDR;
    logic             iBR_JUMP;
    logic [31:0]      iBR_TARGET;
    logic             oBUSY;
    logic             oJUMP_STB;
    logic             oJUMP_PREDICT;
    logic             oJUMP_HIT;
    logic             oJUMP_JUMP;
    logic [31:0]      oJUMP_ADDR;
    logic [31:0]      oJUMP_INST_ADDR;
    logic             oFLUSH;
    logic             oREDIRECT_VALID;
    logic [31:0]      oREDIRECT_ADDR;
    logic             iREDIRECT_ACK;
    logic [CNT_W-1:0] oBRANCH_COUNT;
    logic [CNT_W-1:0] oMISS_COUNT;

    modport master (
        input  iFLUSH, iBR_VALID, iBR_INST_ADDR, iBR_PREDICT, iBR_HIT,
               iBR_PREDICT_ADDR, iBR_JUMP, iBR_TARGET, iREDIRECT_ACK,
        output oBUSY, oJUMP_STB, oJUMP_PREDICT, oJUMP_HIT, oJUMP_JUMP,
               oJUMP_ADDR, oJUMP_INST_ADDR, oFLUSH, oREDIRECT_VALID,
               oREDIRECT_ADDR, oBRANCH_COUNT, oMISS_COUNT
    );

    modport slave (
        output iFLUSH, iBR_VALID, iBR_INST_ADDR, iBR_PREDICT, iBR_HIT,
               iBR_PREDICT_ADDR, iBR_JUMP, iBR_TARGET, iREDIRECT_ACK,
        input  oBUSY, oJUMP_STB, oJUMP_PREDICT, oJUMP_HIT, oJUMP_JUMP,
               oJUMP_ADDR, oJUMP_INST_ADDR, oFLUSH, oREDIRECT_VALID,
               oREDIRECT_ADDR, oBRANCH_COUNT, oMISS_COUNT
    );
endinterface

// File: rtl/execute_branch_resolver.sv
// End-of-execute branch resolver: predictor update strobe, mispredict flush/redirect
// sequencing and saturating hit/miss statistics.
module execute_branch_resolver #(
    parameter int CNT_W = 16
) (
    input  logic iCLOCK,
    input  logic inRESET,
    input  logic iRESET_SYNC,
    execute_branch_resolver_if.master bus
);
    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    state_t           state_reg;
    logic             jump_stb_reg;
    logic             jump_predict_reg;
    logic             jump_hit_reg;
    logic             jump_jump_reg;
    logic [31:0]      jump_addr_reg;
    logic [31:0]      jump_inst_addr_reg;
    logic             flush_reg;
    logic             redirect_valid_reg;
    logic [31:0]      redirect_addr_reg;
    logic [CNT_W-1:0] branch_count_reg;
    logic [CNT_W-1:0] miss_count_reg;

    logic             accept;
    logic             mispredict;
    logic [31:0]      redirect_addr_next;

    // Anything seen while not IDLE, or alongside an external flush, is wrong-path.
    assign accept = bus.iBR_VALID && (state_reg == IDLE) && !bus.iFLUSH;

    assign mispredict = (bus.iBR_JUMP != bus.iBR_PREDICT) ||
                        (bus.iBR_JUMP && bus.iBR_PREDICT &&
                         (bus.iBR_TARGET != bus.iBR_PREDICT_ADDR));

    assign redirect_addr_next = bus.iBR_JUMP ? bus.iBR_TARGET
                                             : bus.iBR_INST_ADDR + 32'd4;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_reg          <= IDLE;
            jump_stb_reg       <= 1'b0;
            jump_predict_reg   <= 1'b0;
            jump_hit_reg       <= 1'b0;
            jump_jump_reg      <= 1'b0;
            jump_addr_reg      <= '0;
            jump_inst_addr_reg <= '0;
            flush_reg          <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_addr_reg  <= '0;
            branch_count_reg   <= '0;
            miss_count_reg     <= '0;
        end else if (iRESET_SYNC) begin
            state_reg          <= IDLE;
            jump_stb_reg       <= 1'b0;
            jump_predict_reg   <= 1'b0;
            jump_hit_reg       <= 1'b0;
            jump_jump_reg      <= 1'b0;
            jump_addr_reg      <= '0;
            jump_inst_addr_reg <= '0;
            flush_reg          <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_addr_reg  <= '0;
            branch_count_reg   <= '0;
            miss_count_reg     <= '0;
        end else begin
            // Update channel and statistics run independently of the FSM.
            jump_stb_reg <= accept;
            if (accept) begin
                jump_predict_reg   <= bus.iBR_PREDICT;
                jump_hit_reg       <= bus.iBR_HIT;
                jump_jump_reg      <= bus.iBR_JUMP;
                jump_addr_reg      <= bus.iBR_TARGET;
                jump_inst_addr_reg <= bus.iBR_INST_ADDR;
                if (branch_count_reg != {CNT_W{1'b1}})
                    branch_count_reg <= branch_count_reg + 1'b1;
                if (mispredict && (miss_count_reg != {CNT_W{1'b1}}))
                    miss_count_reg <= miss_count_reg + 1'b1;
            end

            if (bus.iFLUSH) begin
                state_reg          <= IDLE;
                flush_reg          <= 1'b0;
                redirect_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        flush_reg          <= 1'b0;
                        redirect_valid_reg <= 1'b0;
                        if (accept && mispredict) begin
                            redirect_addr_reg <= redirect_addr_next;
                            flush_reg         <= 1'b1;
                            state_reg         <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        flush_reg          <= 1'b0;
                        redirect_valid_reg <= 1'b1;
                        state_reg          <= REDIRECT;
                    end
                    REDIRECT: begin
                        if (bus.iREDIRECT_ACK) begin
                            redirect_valid_reg <= 1'b0;
                            state_reg          <= IDLE;
                        end
                    end
                    default: begin
                        flush_reg          <= 1'b0;
                        redirect_valid_reg <= 1'b0;
                        state_reg          <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.oBUSY           = (state_reg != IDLE);
    assign bus.oJUMP_STB       = jump_stb_reg;
    assign bus.oJUMP_PREDICT   = jump_predict_reg;
    assign bus.oJUMP_HIT       = jump_hit_reg;
    assign bus.oJUMP_JUMP      = jump_jump_reg;
    assign bus.oJUMP_ADDR      = jump_addr_reg;
    assign bus.oJUMP_INST_ADDR = jump_inst_addr_reg;
    assign bus.oFLUSH          = flush_reg;
    assign bus.oREDIRECT_VALID = redirect_valid_reg;
    assign bus.oREDIRECT_ADDR  = redirect_addr_reg;
    assign bus.oBRANCH_COUNT   = branch_count_reg;
    assign bus.oMISS_COUNT     = miss_count_reg;
endmodule

// File: tb/tb_execute_branch_resolver.sv
// Directed plus randomized bench for execute_branch_resolver against a
// transaction-level model of accept / flush / redirect timing.
module tb_execute_branch_resolver;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic iCLOCK = 1'b0;
    logic inRESET;
    logic iRESET_SYNC;

    execute_branch_resolver_if #(.CNT_W(CNT_W)) bif ();

    execute_branch_resolver #(.CNT_W(CNT_W)) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .bus         (bif)
    );

    always #5 iCLOCK = ~iCLOCK;

    int total = 0;
    int bad   = 0;

    // Reference model: a pending mispredict is remembered by the edge index at
    // which it was accepted; flush/redirect visibility follows from that index.
    int          cyc = 0;
    bit          pending = 0;
    int          acc_c = -10;
    bit          e_stb, e_pred, e_hit, e_jump;
    logic [31:0] e_addr, e_iaddr, e_raddr;
    int          e_bcnt, e_mcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pending = 0; acc_c = -10;
        e_stb = 0; e_pred = 0; e_hit = 0; e_jump = 0;
        e_addr = 0; e_iaddr = 0; e_raddr = 0;
        e_bcnt = 0; e_mcnt = 0;
    endtask

    task automatic model_update();
        bit acc, mis;
        cyc++;
        if (!inRESET || iRESET_SYNC) begin
            model_reset();
            return;
        end
        acc = bif.iBR_VALID && !pending && !bif.iFLUSH;
        mis = (bif.iBR_JUMP != bif.iBR_PREDICT) ||
              (bif.iBR_JUMP && bif.iBR_PREDICT && bif.iBR_TARGET != bif.iBR_PREDICT_ADDR);
        e_stb = acc;
        if (acc) begin
            e_pred = bif.iBR_PREDICT; e_hit = bif.iBR_HIT; e_jump = bif.iBR_JUMP;
            e_addr = bif.iBR_TARGET; e_iaddr = bif.iBR_INST_ADDR;
            if (e_bcnt < MAXC) e_bcnt++;
            if (mis && e_mcnt < MAXC) e_mcnt++;
        end
        if (bif.iFLUSH) pending = 0;
        else if (pending && cyc >= acc_c + 2 && bif.iREDIRECT_ACK) pending = 0;
        else if (acc && mis) begin
            pending = 1;
            acc_c   = cyc;
            e_raddr = bif.iBR_JUMP ? bif.iBR_TARGET : bif.iBR_INST_ADDR + 32'd4;
        end
    endtask

    task automatic check_all();
        bit rv;
        rv = pending && (cyc >= acc_c + 1);
        chk("stb",    bif.oJUMP_STB,       e_stb);
        chk("pred",   bif.oJUMP_PREDICT,   e_pred);
        chk("hit",    bif.oJUMP_HIT,       e_hit);
        chk("jump",   bif.oJUMP_JUMP,      e_jump);
        chk("addr",   bif.oJUMP_ADDR,      e_addr);
        chk("iaddr",  bif.oJUMP_INST_ADDR, e_iaddr);
        chk("flush",  bif.oFLUSH,          pending && (cyc == acc_c));
        chk("rvalid", bif.oREDIRECT_VALID, rv);
        chk("busy",   bif.oBUSY,           pending);
        chk("bcnt",   bif.oBRANCH_COUNT,   e_bcnt);
        chk("mcnt",   bif.oMISS_COUNT,     e_mcnt);
        if (rv) chk("raddr", bif.oREDIRECT_ADDR, e_raddr);
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        model_update();
        #1;
        check_all();
    endtask

    task automatic set_br(input bit v, input logic [31:0] ia, input bit p, input bit h,
                          input logic [31:0] pa, input bit j, input logic [31:0] t);
        bif.iBR_VALID = v; bif.iBR_INST_ADDR = ia; bif.iBR_PREDICT = p; bif.iBR_HIT = h;
        bif.iBR_PREDICT_ADDR = pa; bif.iBR_JUMP = j; bif.iBR_TARGET = t;
    endtask

    // Presents one branch for one cycle, then leaves the result visible (N+1).
    task automatic send(input logic [31:0] ia, input bit p, input bit h,
                        input logic [31:0] pa, input bit j, input logic [31:0] t);
        set_br(1, ia, p, h, pa, j, t);
        $display("txn inst=%08h pred=%0b jump=%0b paddr=%08h target=%08h", ia, p, j, pa, t);
        tick();
        bif.iBR_VALID = 0;
    endtask

    task automatic ack_now();
        bif.iREDIRECT_ACK = 1;
        tick();
        bif.iREDIRECT_ACK = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stb"},   bif.oJUMP_STB, 0);
        chk({tag, "_flush"}, bif.oFLUSH, 0);
        chk({tag, "_rv"},    bif.oREDIRECT_VALID, 0);
        chk({tag, "_raddr"}, bif.oREDIRECT_ADDR, 0);
        chk({tag, "_busy"},  bif.oBUSY, 0);
        chk({tag, "_bcnt"},  bif.oBRANCH_COUNT, 0);
        chk({tag, "_mcnt"},  bif.oMISS_COUNT, 0);
        chk({tag, "_jaddr"}, bif.oJUMP_ADDR, 0);
    endtask

    initial begin
        inRESET = 0; iRESET_SYNC = 0;
        bif.iFLUSH = 0; bif.iREDIRECT_ACK = 0;
        set_br(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check_all_zero("reset");
        tick(); tick();
        @(negedge iCLOCK); inRESET = 1;
        tick();

        // 1: three back-to-back correct predictions
        set_br(1, 32'h1000, 1, 1, 32'h100, 1, 32'h100); tick();
        set_br(1, 32'h1004, 1, 1, 32'h100, 1, 32'h100); tick();
        set_br(1, 32'h1008, 1, 1, 32'h100, 1, 32'h100); tick();
        bif.iBR_VALID = 0;
        chk("t1_bcnt", bif.oBRANCH_COUNT, 3);
        chk("t1_mcnt", bif.oMISS_COUNT, 0);
        tick();

        // 2: direction mispredict, ack in fourth cycle after accept
        send(32'h2000, 1, 1, 32'h3000, 0, 32'h3000);          // now N+1
        chk("t2_flush", bif.oFLUSH, 1);
        chk("t2_jump",  bif.oJUMP_JUMP, 0);
        tick();                                               // N+2
        chk("t2_rv",    bif.oREDIRECT_VALID, 1);
        chk("t2_raddr", bif.oREDIRECT_ADDR, 32'h2004);
        tick(); tick();                                       // N+4
        ack_now();                                            // N+5
        chk("t2_busy",  bif.oBUSY, 0);
        chk("t2_mcnt",  bif.oMISS_COUNT, 1);

        // 3: no-mispredict at wrap address, wrap redirect, target mispredict
        send(32'hFFFFFFFC, 0, 0, 32'h0, 0, 32'h0);
        chk("t3_noflush", bif.oFLUSH, 0);
        tick();
        send(32'hFFFFFFFC, 1, 1, 32'h80, 0, 32'h80);
        tick();
        chk("t3_wrap", bif.oREDIRECT_ADDR, 32'h0);
        ack_now();
        send(32'h500, 1, 1, 32'h80, 1, 32'h40);
        tick();
        chk("t3_target", bif.oREDIRECT_ADDR, 32'h40);

        // 4: valid held high through redirect and ack cycle (wrong-path)
        set_br(1, 32'h600, 1, 1, 32'h700, 1, 32'h700);
        tick();
        chk("t4_busy", bif.oBUSY, 1);
        ack_now();
        bif.iBR_VALID = 0;
        tick();

        // 5: external flush during redirect, branch alongside it dropped
        send(32'h800, 0, 0, 32'h0, 1, 32'h900);
        tick();
        bif.iFLUSH = 1;
        set_br(1, 32'h810, 1, 1, 32'h100, 1, 32'h100);
        tick();
        bif.iFLUSH = 0; bif.iBR_VALID = 0;
        chk("t5_rv", bif.oREDIRECT_VALID, 0);
        tick();
        chk("t5_nostb", bif.oJUMP_STB, 0);
        send(32'h820, 1, 1, 32'h100, 1, 32'h100);
        chk("t5_stb", bif.oJUMP_STB, 1);

        // 6: miss counter saturation, then async reset mid-redirect
        for (int k = 0; k < 17; k++) begin
            send(32'hA00 + 32'(k * 4), 1, 0, 32'h0, 0, 32'h0);
            tick();
            ack_now();
        end
        chk("t6_sat", bif.oMISS_COUNT, 4'hF);
        send(32'hB00, 1, 0, 32'h0, 0, 32'h0);
        tick();
        inRESET = 0;
        #2;
        model_reset();
        check_all_zero("areset");
        tick();
        @(negedge iCLOCK); inRESET = 1;
        tick();
        send(32'hC00, 0, 0, 32'h0, 1, 32'hD00);
        tick();
        iRESET_SYNC = 1;
        tick();
        iRESET_SYNC = 0;
        check_all_zero("sreset");

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] pa;
            pa = {$urandom_range(0, 7), 4'h0};
            set_br(($urandom % 3) != 0,
                   ($urandom % 8 == 0) ? 32'hFFFFFFFC : $urandom,
                   $urandom % 2, $urandom % 2, pa, ($urandom % 4) != 0,
                   ($urandom % 2) ? pa : {$urandom_range(0, 7), 4'h0});
            bif.iREDIRECT_ACK = ($urandom % 3) == 0;
            bif.iFLUSH        = ($urandom % 40) == 0;
            iRESET_SYNC       = ($urandom % 300) == 0;
            tick();
        end
        bif.iBR_VALID = 0; bif.iFLUSH = 0; iRESET_SYNC = 0; bif.iREDIRECT_ACK = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
